// File: rtl/vpl_addsub_pkg.sv
// vpl_addsub_pkg: shared constants, FSM state type and overflow helper for the serial add/sub unit
package vpl_addsub_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
endpackage

// File: rtl/vpl_serial_addsub_if.sv
// vpl_serial_addsub_if: command/result valid-ready bundle for the serial add/sub unit
interface vpl_serial_addsub_if #(parameter int NIBBLES = 4);
  import vpl_addsub_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  modport master(output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum, cout, ovf, zero);
  modport slave(input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/vpl_nibble_slice.sv
// vpl_nibble_slice: 4-bit adder slice with carry-in and sub-controlled B inversion
module vpl_nibble_slice (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout
);
  assign {cout, s4} = {1'b0, a4} + {1'b0, b4 ^ {4{sub}}} + {4'b0, cin};
endmodule

// File: rtl/vpl_serial_addsub.sv
// vpl_serial_addsub: W-bit add/sub streamed one nibble per cycle through a single slice, LSB nibble first
module vpl_serial_addsub
  import vpl_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic               clk,
  input logic               rst,
  vpl_serial_addsub_if.slave bus
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_sub;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;
  logic           r_zero;
  logic [IW-1:0]  r_idx;
  logic [3:0]     w_a4;
  logic [3:0]     w_b4;
  logic [3:0]     w_s4;
  logic           w_c;
  logic           w_last;
  logic [W-1:0]   w_sum_next;
  assign w_a4   = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b4   = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_last = r_idx == IW'(NIBBLES - 1);
  vpl_nibble_slice u_slice (
    .a4  (w_a4),
    .b4  (w_b4),
    .sub (r_sub),
    .cin (r_carry),
    .s4  (w_s4),
    .cout(w_c)
  );
  // full-width view of the sum with the current nibble merged, so zero sees the final nibble
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[r_idx*NIBBLE_W +: NIBBLE_W] = w_s4;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (bus.in_valid ? RUN : IDLE)
           : r_state == RUN  ? (w_last ? DONE : RUN)
           : (bus.out_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready  = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    bus.sum       = r_sum;
    bus.cout      = r_cout;
    bus.ovf       = r_ovf;
    bus.zero      = r_zero;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (r_state == IDLE && bus.in_valid) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sub   <= bus.sub;
      r_carry <= bus.sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_c;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c;
        r_ovf  <= ovf_f(r_a[W-1], r_b[W-1] ^ r_sub, w_s4[3]);
        r_zero <= w_sum_next == '0;
      end
    end
  end
endmodule

// File: doc/vpl_serial_addsub.md
Name: vpl_serial_addsub

Overview:
- Multi-cycle W-bit add/subtract unit. It streams operands one 4-bit nibble per cycle through a single nibble adder slice, least-significant nibble first.
- The carry is held in a register between nibbles.
- Sits directly upstream of the 4-bit ripple-carry add/sub datapath. It supplies nibble operands and carry-in, and assembles the full-width result with status flags.
- Valid/ready handshake on both the command side and the result side.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles; operand width W = 4*NIBBLES (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- a  input  W  operand A.
- b  input  W  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. Reset is fixed; there is no asynchronous path.
- Reset values:
  - State is IDLE.
  - in_ready = 1; out_valid = 0.
  - sum, cout, ovf and zero are all 0.
  - The internal nibble index and carry register are 0.
- States:
  - IDLE: in_ready = 1. When in_valid is 1 at an edge, latch a, b and sub. Set carry_reg = sub and idx = 0, then go to RUN.
  - RUN: in_ready = 0 and out_valid = 0. Each cycle the slice computes {c, s} = a[idx] + (b[idx] XOR {4{sub}}) + carry_reg. At the edge, write s into sum[idx], set carry_reg <= c and increment idx. On the edge where idx == NIBBLES-1, go to DONE and register cout = c.
    - ovf is registered on the same edge. ovf = (a[W-1] == b'[W-1]) && (s[3] != a[W-1]), where b' is b XOR {W{sub}}.
    - zero is registered as (assembled sum == 0), including the final nibble.
  - DONE: out_valid = 1. sum and all flags are held stable while out_ready = 0. When out_ready is 1 at an edge, go to IDLE.
- Latency: a command accepted at the edge ending cycle T gives out_valid = 1 in cycle T+NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles. There is no DONE-to-RUN bypass; a new command is only taken in IDLE.
- sum, cout, ovf and zero keep their last result values in IDLE. They change only in RUN.
- in_valid is ignored outside IDLE. Operands are latched at accept, so the upstream may change a, b and sub after the handshake.
- Width rules:
  - The carry chain is modulo 2^W.
  - cout is bit W of a + b' + sub.
  - The sum wraps naturally; no saturation.
- Reset mid-operation (RUN or DONE) aborts with no output handshake. Registers return to reset values on that edge. in_ready = 1 in the next cycle.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes. The command waits for IDLE.

Decomposition:
- Shared package vpl_addsub_pkg:
  - constant NIBBLE_W = 4;
  - state enum {IDLE, RUN, DONE};
  - helper function for the signed-overflow expression.
- One sub-module, vpl_nibble_slice: 4-bit add with separate carry-in and sub-controlled B inversion. Combinational, ports a4, b4, sub, cin, s4, cout.
- Top: FSM, operand/result registers, idx counter of width clog2(NIBBLES), flag logic.

Test Plan (NIBBLES=4, W=16):
- Add: a=0x1234, b=0x0FFF, sub=0 -> sum=0x2233, cout=0, ovf=0, zero=0. out_valid exactly 5 cycles after the accept cycle.
- Borrow: a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0.
- Signed overflow:
  - a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0.
  - a=0x8000, b=0x0001, sub -> sum=0x7FFF, ovf=1, cout=1.
- Wrap/zero: a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, zero=1, ovf=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while in_valid=1 with new operands. Required: sum and flags stable, in_ready=0. After out_ready=1, IDLE accepts the new command the following cycle.
- Reset mid-RUN: assert rst at idx=2. Required: next cycle out_valid=0, in_ready=1, sum=0. A subsequent 0x0003+0x0004 returns 0x0007.
